// File: rtl/gpr_arb_pkg.sv
// gpr_arb_pkg: shared widths and write-request type for the GPR write arbiter.
package gpr_arb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/gpr_write_arbiter_if.sv
// gpr_write_arbiter_if: writeback, MDU, decode and GPR-port signals of the arbiter.
interface gpr_write_arbiter_if #(parameter int DEPTH = 4);
  import gpr_arb_pkg::*;
  logic                    WbWrite, MduValid, MduReady, PendHit1, PendHit2, StallReq, RegWrite;
  logic [REG_AW-1:0]       WbAddr, MduAddr, RS1, RS2, WA;
  logic [DATA_W-1:0]       WbData, MduData, WData;
  logic [$clog2(DEPTH):0]  Count;
  modport master (output WbWrite, WbAddr, WbData, MduValid, MduAddr, MduData, RS1, RS2,
                  input MduReady, PendHit1, PendHit2, StallReq, WA, WData, RegWrite, Count);
  modport slave  (input WbWrite, WbAddr, WbData, MduValid, MduAddr, MduData, RS1, RS2,
                  output MduReady, PendHit1, PendHit2, StallReq, WA, WData, RegWrite, Count);
endinterface

// File: rtl/gpr_arb_fifo.sv
// gpr_arb_fifo: circular MDU result queue with parallel address compare for pending-write hits.
module gpr_arb_fifo
  import gpr_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  wr_req_t           din,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output wr_req_t           head,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              hit1,
  output logic              hit2
);
  wr_req_t           mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [DEPTH-1:0]  m1, m2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= din;
  // An entry is live when its distance from the read pointer is below the occupancy
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [AW-1:0] off;
    logic          vld;
    assign off   = AW'(e) - rd_ptr_q;
    assign vld   = {1'b0, off} < count_q;
    assign m1[e] = vld && mem_q[e].addr == rs1;
    assign m2[e] = vld && mem_q[e].addr == rs2;
  end
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign hit1  = rs1 != ZERO_REG && |m1;
  assign hit2  = rs2 != ZERO_REG && |m2;
endmodule

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: shares the GPR write port between writeback (priority) and queued MDU results.
// Optional GPRARB_BYPASS_EN: an MDU result writes straight through when the queue is empty and writeback is idle.
module gpr_write_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic                 Clk,
  input logic                 Reset_n,
  gpr_write_arbiter_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  logic             wb_we, fire, byp, push, pop, full, empty;
  wr_req_t          head;
  logic [AW:0]      count;
  logic [AGE_W-1:0] age_q, age_d;
  logic             stall_q, stall_d;
  assign wb_we        = bus.WbWrite && bus.WbAddr != ZERO_REG;
  assign pop          = !empty && !wb_we;
  assign bus.MduReady = !full || pop;
  // Results for $0 complete the handshake but are simply discarded
  assign fire = bus.MduValid && bus.MduReady && bus.MduAddr != ZERO_REG;
`ifdef GPRARB_BYPASS_EN
  assign byp = fire && empty && !wb_we;
`else
  assign byp = 1'b0;
`endif
  assign push = fire && !byp;
  gpr_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push),
    .pop   (pop),
    .din   ('{addr: bus.MduAddr, data: bus.MduData}),
    .rs1   (bus.RS1),
    .rs2   (bus.RS2),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty),
    .hit1  (bus.PendHit1),
    .hit2  (bus.PendHit2)
  );
  always_comb begin
    bus.RegWrite = wb_we || pop || byp;
    bus.WA       = wb_we ? bus.WbAddr : pop ? head.addr : byp ? bus.MduAddr : ZERO_REG;
    bus.WData    = wb_we ? bus.WbData : pop ? head.data : byp ? bus.MduData : '0;
    age_d        = (empty || pop) ? '0 : age_q == AGE_W'(MAX_WAIT) ? age_q : age_q + 1'b1;
    stall_d      = !pop && (stall_q || age_d == AGE_W'(MAX_WAIT) || full ||
                            (push && count == (AW+1)'(DEPTH - 1)));
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  assign bus.StallReq = stall_q;
  assign bus.Count    = count;
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb_gpr_write_arbiter: directed checks of write-port muxing, MDU queueing, starvation stall and reset.
module tb_gpr_write_arbiter;
  import gpr_arb_pkg::*;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] mq[$];
  always #5 Clk = ~Clk;
  gpr_write_arbiter_if #(.DEPTH(4)) bus ();
  gpr_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Address-only shadow of the queue, used to flag writeback hazards on queued registers
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) mq.delete();
    else begin
      automatic logic wbw = bus.WbWrite && bus.WbAddr != 5'd0;
      automatic logic p   = mq.size() != 0 && !wbw;
      automatic logic psh = bus.MduValid && (mq.size() < 4 || p) && bus.MduAddr != 5'd0;
`ifdef GPRARB_BYPASS_EN
      if (mq.size() == 0 && !wbw) psh = 1'b0;
`endif
      if (p) void'(mq.pop_front());
      if (psh) mq.push_back(bus.MduAddr);
    end

  always @(negedge Clk)
    if (Reset_n && bus.WbWrite && bus.WbAddr != 5'd0)
      foreach (mq[i])
        if (mq[i] == bus.WbAddr) begin
          n_bad++;
          $error("FAIL protocol: writeback to r%0d while queued (observed hazard, expected none)", bus.WbAddr);
        end

  initial begin
    bus.WbWrite = 0; bus.WbAddr = 0; bus.WbData = 0;
    bus.MduValid = 0; bus.MduAddr = 0; bus.MduData = 0;
    bus.RS1 = 0; bus.RS2 = 0;
    #1;
    chk("rst_count", bus.Count, 0);
    chk("rst_stall", bus.StallReq, 0);
    chk("rst_ready", bus.MduReady, 1);
    chk("rst_regwrite", bus.RegWrite, 0);
    step(); step();
    Reset_n = 1;
    // Writeback passes straight through
    bus.WbWrite = 1; bus.WbAddr = 8; bus.WbData = 32'h1234;
    #1;
    chk("wb_wa", bus.WA, 8);
    chk("wb_wdata", bus.WData, 32'h1234);
    chk("wb_regwrite", bus.RegWrite, 1);
    chk("wb_count", bus.Count, 0);
    step();
    bus.WbWrite = 0;
    // Single MDU result on an idle writeback
    bus.MduValid = 1; bus.MduAddr = 9; bus.MduData = 32'hAAAA;
    #1;
`ifdef GPRARB_BYPASS_EN
    chk("byp_regwrite", bus.RegWrite, 1);
    chk("byp_wa", bus.WA, 9);
    chk("byp_wdata", bus.WData, 32'hAAAA);
    step();
    bus.MduValid = 0;
    #1;
    chk("byp_count", bus.Count, 0);
`else
    chk("mdu_nowrite_same_cycle", bus.RegWrite, 0);
    chk("mdu_ready", bus.MduReady, 1);
    step();
    bus.MduValid = 0;
    #1;
    chk("mdu_count1", bus.Count, 1);
    chk("mdu_wa", bus.WA, 9);
    chk("mdu_wdata", bus.WData, 32'hAAAA);
    chk("mdu_regwrite", bus.RegWrite, 1);
    step();
    chk("mdu_count0", bus.Count, 0);
    chk("mdu_idle", bus.RegWrite, 0);
`endif
    // Blocked head ages into a stall request
    bus.WbWrite = 1; bus.WbAddr = 8; bus.WbData = 32'h77;
    bus.MduValid = 1; bus.MduAddr = 10; bus.MduData = 32'h55;
    step();
    bus.MduValid = 0;
    chk("age_count", bus.Count, 1);
    chk("age_stall0", bus.StallReq, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("age_stall_early", bus.StallReq, 0);
    end
    step();
    chk("age_stall_set", bus.StallReq, 1);
    step();
    chk("age_stall_hold", bus.StallReq, 1);
    chk("age_wb_wins", bus.WA, 8);
    bus.WbWrite = 0;
    #1;
    chk("age_drain_wa", bus.WA, 10);
    chk("age_drain_wdata", bus.WData, 32'h55);
    chk("age_drain_regwrite", bus.RegWrite, 1);
    step();
    chk("age_stall_clear", bus.StallReq, 0);
    chk("age_count0", bus.Count, 0);
    // Fill the queue behind writeback, then drain in order
    bus.WbWrite = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.MduValid = 1; bus.MduAddr = 5'(i); bus.MduData = 32'h100 + i;
      #1;
      chk("fill_ready", bus.MduReady, 1);
      step();
    end
    bus.MduValid = 0;
    #1;
    chk("full_count", bus.Count, 4);
    chk("full_ready", bus.MduReady, 0);
    chk("full_stall", bus.StallReq, 1);
    bus.WbWrite = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_wa", bus.WA, i);
      chk("drain_wdata", bus.WData, 32'h100 + i);
      chk("drain_regwrite", bus.RegWrite, 1);
      step();
    end
    chk("drain_count", bus.Count, 0);
    chk("drain_stall", bus.StallReq, 0);
    chk("drain_idle", bus.RegWrite, 0);
    // Pending-write hits and a dropped $0 result
    bus.WbWrite = 1;
    bus.MduValid = 1; bus.MduAddr = 5; bus.MduData = 32'h5;
    step();
    bus.MduValid = 0; bus.RS1 = 5; bus.RS2 = 0;
    #1;
    chk("hit_count", bus.Count, 1);
    chk("hit1", bus.PendHit1, 1);
    chk("hit2_zero", bus.PendHit2, 0);
    bus.RS2 = 7;
    #1;
    chk("hit2_other", bus.PendHit2, 0);
    bus.MduValid = 1; bus.MduAddr = 0; bus.MduData = 32'hDEAD;
    #1;
    chk("r0_ready", bus.MduReady, 1);
    step();
    bus.MduValid = 0;
    #1;
    chk("r0_count", bus.Count, 1);
    bus.WbWrite = 0;
    #1;
    chk("r0_drain_wa", bus.WA, 5);
    chk("hit_while_pop", bus.PendHit1, 1);
    step();
    chk("r0_count0", bus.Count, 0);
    chk("r0_never_written", bus.RegWrite, 0);
    chk("hit_gone", bus.PendHit1, 0);
    // Reset with queued entries
    bus.WbWrite = 1;
    for (int i = 11; i <= 13; i++) begin
      bus.MduValid = 1; bus.MduAddr = 5'(i); bus.MduData = 32'(i);
      step();
    end
    bus.MduValid = 0;
    chk("prerst_count", bus.Count, 3);
    bus.WbWrite = 0;
    #2;
    Reset_n = 0;
    #1;
    chk("midrst_count", bus.Count, 0);
    chk("midrst_stall", bus.StallReq, 0);
    chk("midrst_regwrite", bus.RegWrite, 0);
    step(); step();
    Reset_n = 1;
    step(); step();
    chk("postrst_regwrite", bus.RegWrite, 0);
    chk("postrst_count", bus.Count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_write_arbiter.md
Name: gpr_write_arbiter

Overview:
- Shares the single GPR write port (WA/WData/RegWrite) between the pipeline writeback stage and the multi-cycle mult/div unit (MDU).
- Writeback always wins. MDU results queue in a small FIFO and drain on idle writeback cycles.
- An age counter raises a stall request so queued MDU results cannot starve.
- Gives decode a pending-write hit for RS1/RS2 so reads never see stale data.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
- MAX_WAIT, 8, cycles the FIFO head may be blocked before StallReq asserts (>=1)

Ports:
- Clk  in  1  clock, posedge for all arbiter state
- Reset_n  in  1  asynchronous active-low reset
- WbWrite  in  1  writeback stage requests a GPR write this cycle
- WbAddr  in  5  writeback destination register
- WbData  in  32  writeback data
- MduValid  in  1  MDU offers a result
- MduReady  out  1  FIFO can accept; transfer when MduValid&&MduReady
- MduAddr  in  5  MDU destination register
- MduData  in  32  MDU result
- RS1  in  5  decode read address 1
- RS2  in  5  decode read address 2
- PendHit1  out  1  RS1 (non-zero) matches a valid FIFO entry
- PendHit2  out  1  RS2 (non-zero) matches a valid FIFO entry
- StallReq  out  1  registered; asks the pipeline to idle writeback
- WA  out  5  to GPR write address
- WData  out  32  to GPR write data
- RegWrite  out  1  to GPR write enable
- Count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, Reset_n=0):
  - FIFO empty, Count=0, age=0, StallReq=0, MduReady=1.
  - WA/WData/RegWrite are combinational; they read 0 while WbWrite=0.
- Write port is a combinational mux:
  - Writeback writes when WbWrite=1 and WbAddr!=0.
  - Otherwise the FIFO head writes when the FIFO is non-empty; the head is popped at posedge.
  - Otherwise RegWrite=0, WA=0, WData=0.
- Writes to $0:
  - WbWrite with WbAddr=0 does not assert RegWrite and does not block the FIFO head; the head drains that cycle.
  - An MDU result with MduAddr=0 is accepted and dropped. It is never enqueued and never produces a write.
- FIFO:
  - Circular buffer, wrap-around pointers, DEPTH entries.
  - MduReady = (Count<DEPTH) || pop-this-cycle. Simultaneous push and pop when full is legal; Count is unchanged.
  - Push and pop in the same cycle when empty (non-bypass build): the entry is pushed and not popped; the head is written the next cycle at the earliest.
- Ordering:
  - FIFO writes retire in acceptance order.
  - If WbAddr matches a queued entry, the later FIFO write would overwrite it. Decode uses PendHit to stall issue to that register, so this case is forbidden. The bench flags it as a protocol error.
- PendHit:
  - Combinational compare of RS1/RS2 against all valid entries; 0 for address 0.
  - An entry being popped this cycle still hits.
- Age/StallReq:
  - age increments each cycle the FIFO is non-empty and the head is blocked by a writeback write.
  - age clears on pop or when the FIFO is empty, and saturates at MAX_WAIT.
  - StallReq is registered: set at the posedge where age reaches MAX_WAIT or the FIFO becomes full; cleared at the first posedge after a pop.
  - The pipeline deasserts WbWrite the cycle after StallReq=1. If WbWrite stays high, writeback still wins.
- Reset mid-operation discards all queued entries. No write is issued during or after reset until new requests arrive.

Optional Feature:
- GPRARB_BYPASS_EN defined:
  - If the FIFO is empty and writeback is not writing, an MDU handshake (MduAddr!=0) drives WA/WData/RegWrite in the same cycle and is not enqueued.
  - PendHit does not see bypassed entries.
- Undefined: every accepted MDU result enters the FIFO, so write latency is at least 1 cycle.

Decomposition:
- Shared package gpr_arb_pkg:
  - REG_AW=5, DATA_W=32, ZERO_REG=5'd0
  - typedef wr_req_t {addr, data}
- Sub-module: gpr_arb_fifo (storage, pointers, Count, parallel address-compare outputs). Port mux, age counter and StallReq stay in the top.

Test Plan:
- Reset, then WbWrite=1, WbAddr=8, WbData=0x1234 -> same cycle WA=8, WData=0x1234, RegWrite=1; Count=0.
- MDU result (addr 9, data 0xAAAA) with WbWrite=0 -> non-bypass: enqueued, next cycle WA=9 RegWrite=1, Count 1->0. Bypass: written in the same cycle.
- WbWrite=1 held for 10 cycles while one MDU entry is queued -> StallReq=1 after MAX_WAIT=8 blocked cycles. Drop WbWrite -> entry written, StallReq clears the next posedge.
- Push 4 MDU results with WbWrite=1 throughout -> Count=4, MduReady=0, StallReq=1. Then idle writeback -> entries written in order addr 1,2,3,4.
- Queue an entry to r5, set RS1=5, RS2=0 -> PendHit1=1, PendHit2=0. An MDU result to r0 -> accepted, never written, Count unchanged.
- Assert Reset_n=0 with 3 entries queued -> Count=0, StallReq=0 immediately. After release, RegWrite stays 0 with no requests.
